// File: rtl/fp32_pipelined_adder.sv
// fp32_pipelined_adder: binary32 adder, round-to-nearest-even, flush-to-zero.
// Operands sampled at edge N produce dataOut/validOut after edge N+4.
// Register stages: unpack/compare, align, add/sub, normalize, round/pack.
module fp32_pipelined_adder (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [31:0] dataAIn,
    input  logic [31:0] dataBIn,
    input  logic        validIn,
    output logic [31:0] dataOut,
    output logic        validOut
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic [4:0] valid_q;

    // stage 1: unpack, flush subnormals, order by magnitude, flag specials
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b, nan_d;
    logic [30:0] a_mag, b_mag;
    logic [23:0] a_mant, b_mant;
    logic [7:0]  a_exp, b_exp;
    logic        s1_sign_l_q, s1_sign_s_q, s1_special_q, s1_zero_sign_q;
    logic [7:0]  s1_exp_l_q, s1_exp_diff_q;
    logic [23:0] s1_mant_l_q, s1_mant_s_q;
    logic [31:0] s1_special_val_q;

    // stage 2: aligned operands as 27-bit {mant, guard, round, sticky}
    logic [50:0] align_full;
    logic [26:0] s2_mant_s_d;
    logic        s2_sign_l_q, s2_eff_sub_q, s2_special_q, s2_zero_sign_q;
    logic [7:0]  s2_exp_l_q;
    logic [26:0] s2_mant_l_q, s2_mant_s_q;
    logic [31:0] s2_special_val_q;

    // stage 3: magnitude sum/difference with carry bit
    logic [27:0] s3_sum_d, s3_sum_q;
    logic        s3_sign_l_q, s3_special_q, s3_zero_sign_q;
    logic [7:0]  s3_exp_l_q;
    logic [31:0] s3_special_val_q;

    // stage 4: normalized mantissa and exponent
    logic               lzc_found;
    logic [4:0]         lzc;
    logic [26:0]        s4_mant_d, s4_mant_q;
    logic signed [9:0]  s4_exp_d, s4_exp_q;
    logic               s4_zero_d, s4_zero_q, s4_sign_d, s4_sign_q, s4_special_q;
    logic [31:0]        s4_special_val_q;

    // output stage: rounding and packing
    logic               round_up;
    logic [24:0]        mant_rnd;
    logic signed [9:0]  exp_rnd;
    logic [31:0]        data_d, data_q;

    // Zero operands get exponent and mantissa 0 so they always sort as the smaller side.
    always_comb begin
        a_zero = (dataAIn[30:23] == 8'h00);
        b_zero = (dataBIn[30:23] == 8'h00);
        a_inf  = (dataAIn[30:23] == 8'hFF) && (dataAIn[22:0] == 23'd0);
        b_inf  = (dataBIn[30:23] == 8'hFF) && (dataBIn[22:0] == 23'd0);
        a_nan  = (dataAIn[30:23] == 8'hFF) && (dataAIn[22:0] != 23'd0);
        b_nan  = (dataBIn[30:23] == 8'hFF) && (dataBIn[22:0] != 23'd0);
        a_mag  = a_zero ? 31'd0 : dataAIn[30:0];
        b_mag  = b_zero ? 31'd0 : dataBIn[30:0];
        a_mant = a_zero ? 24'd0 : {1'b1, dataAIn[22:0]};
        b_mant = b_zero ? 24'd0 : {1'b1, dataBIn[22:0]};
        a_exp  = a_zero ? 8'd0 : dataAIn[30:23];
        b_exp  = b_zero ? 8'd0 : dataBIn[30:23];
        a_ge_b = (a_mag >= b_mag);
        nan_d  = a_nan | b_nan | (a_inf & b_inf & (dataAIn[31] ^ dataBIn[31]));
    end

    // Stage 1 register. Zero-result sign is set only when both inputs are negative.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            s1_sign_l_q <= 1'b0; s1_sign_s_q <= 1'b0; s1_exp_l_q <= 8'd0; s1_exp_diff_q <= 8'd0;
            s1_mant_l_q <= 24'd0; s1_mant_s_q <= 24'd0; s1_special_q <= 1'b0;
            s1_special_val_q <= 32'd0; s1_zero_sign_q <= 1'b0;
        end else begin
            s1_sign_l_q      <= a_ge_b ? dataAIn[31] : dataBIn[31];
            s1_sign_s_q      <= a_ge_b ? dataBIn[31] : dataAIn[31];
            s1_exp_l_q       <= a_ge_b ? a_exp : b_exp;
            s1_exp_diff_q    <= a_ge_b ? (a_exp - b_exp) : (b_exp - a_exp);
            s1_mant_l_q      <= a_ge_b ? a_mant : b_mant;
            s1_mant_s_q      <= a_ge_b ? b_mant : a_mant;
            s1_special_q     <= nan_d | a_inf | b_inf;
            s1_special_val_q <= nan_d ? QNAN :
                                a_inf ? {dataAIn[31], 8'hFF, 23'd0} : {dataBIn[31], 8'hFF, 23'd0};
            s1_zero_sign_q   <= dataAIn[31] & dataBIn[31];
        end
    end

    // Right-shift the smaller mantissa; everything below the round bit folds into sticky.
    always_comb begin
        align_full = {s1_mant_s_q, 27'd0} >> s1_exp_diff_q;
        if (s1_exp_diff_q >= 8'd27)
            s2_mant_s_d = {26'd0, |s1_mant_s_q};
        else
            s2_mant_s_d = {align_full[50:25], align_full[24] | (|align_full[23:0])};
    end

    // Stage 2 register.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            s2_sign_l_q <= 1'b0; s2_eff_sub_q <= 1'b0; s2_exp_l_q <= 8'd0; s2_mant_l_q <= 27'd0;
            s2_mant_s_q <= 27'd0; s2_special_q <= 1'b0; s2_special_val_q <= 32'd0; s2_zero_sign_q <= 1'b0;
        end else begin
            s2_sign_l_q      <= s1_sign_l_q;
            s2_eff_sub_q     <= s1_sign_l_q ^ s1_sign_s_q;
            s2_exp_l_q       <= s1_exp_l_q;
            s2_mant_l_q      <= {s1_mant_l_q, 3'b000};
            s2_mant_s_q      <= s2_mant_s_d;
            s2_special_q     <= s1_special_q;
            s2_special_val_q <= s1_special_val_q;
            s2_zero_sign_q   <= s1_zero_sign_q;
        end
    end

    // L is never smaller than S, so the difference cannot go negative.
    always_comb begin
        if (s2_eff_sub_q)
            s3_sum_d = {1'b0, s2_mant_l_q} - {1'b0, s2_mant_s_q};
        else
            s3_sum_d = {1'b0, s2_mant_l_q} + {1'b0, s2_mant_s_q};
    end

    // Stage 3 register.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            s3_sum_q <= 28'd0; s3_sign_l_q <= 1'b0; s3_exp_l_q <= 8'd0;
            s3_special_q <= 1'b0; s3_special_val_q <= 32'd0; s3_zero_sign_q <= 1'b0;
        end else begin
            s3_sum_q         <= s3_sum_d;
            s3_sign_l_q      <= s2_sign_l_q;
            s3_exp_l_q       <= s2_exp_l_q;
            s3_special_q     <= s2_special_q;
            s3_special_val_q <= s2_special_val_q;
            s3_zero_sign_q   <= s2_zero_sign_q;
        end
    end

    // Normalize: carry shifts right into sticky, otherwise leading-zero left shift.
    always_comb begin
        lzc       = 5'd0;
        lzc_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lzc_found) begin
                if (s3_sum_q[i]) lzc_found = 1'b1;
                else             lzc = lzc + 5'd1;
            end
        end
        if (s3_sum_q[27]) begin
            s4_mant_d = {s3_sum_q[27:2], s3_sum_q[1] | s3_sum_q[0]};
            s4_exp_d  = $signed({2'b00, s3_exp_l_q}) + 10'sd1;
        end else begin
            s4_mant_d = s3_sum_q[26:0] << lzc;
            s4_exp_d  = $signed({2'b00, s3_exp_l_q}) - $signed({5'd0, lzc});
        end
        s4_zero_d = (s3_sum_q == 28'd0) || (!s3_sum_q[27] && (s4_exp_d <= 10'sd0));
        s4_sign_d = (s3_sum_q == 28'd0) ? s3_zero_sign_q : s3_sign_l_q;
    end

    // Stage 4 register.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            s4_mant_q <= 27'd0; s4_exp_q <= 10'sd0; s4_zero_q <= 1'b0; s4_sign_q <= 1'b0;
            s4_special_q <= 1'b0; s4_special_val_q <= 32'd0;
        end else begin
            s4_mant_q        <= s4_mant_d;
            s4_exp_q         <= s4_exp_d;
            s4_zero_q        <= s4_zero_d;
            s4_sign_q        <= s4_sign_d;
            s4_special_q     <= s3_special_q;
            s4_special_val_q <= s3_special_val_q;
        end
    end

    // Round to nearest even on G/R/S, renormalize a rounding carry, then pack.
    always_comb begin
        round_up = s4_mant_q[2] & (s4_mant_q[1] | s4_mant_q[0] | s4_mant_q[3]);
        mant_rnd = {1'b0, s4_mant_q[26:3]} + {24'd0, round_up};
        exp_rnd  = s4_exp_q + $signed({9'd0, mant_rnd[24]});
        if (s4_special_q)
            data_d = s4_special_val_q;
        else if (s4_zero_q)
            data_d = {s4_sign_q, 31'd0};
        else if (exp_rnd >= 10'sd255)
            data_d = {s4_sign_q, 8'hFF, 23'd0};
        else
            data_d = {s4_sign_q, exp_rnd[7:0], mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0]};
    end

    // Output register and valid delay line.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            data_q  <= 32'd0;
            valid_q <= 5'd0;
        end else begin
            data_q  <= data_d;
            valid_q <= {valid_q[3:0], validIn};
        end
    end

    assign dataOut  = data_q;
    assign validOut = valid_q[4];

endmodule

// File: tb/tb_fp32_pipelined_adder.sv
// Directed and streaming bench for fp32_pipelined_adder.
module tb_fp32_pipelined_adder;
    logic        clkIn = 1'b0;
    logic        rstIn;
    logic [31:0] dataAIn, dataBIn;
    logic        validIn;
    logic [31:0] dataOut;
    logic        validOut;

    int tests_run = 0;
    int tests_failed = 0;

    logic        mon_en;
    logic [4:0]  v_hist;
    logic [31:0] exp_q[$];

    fp32_pipelined_adder dut (
        .clkIn(clkIn), .rstIn(rstIn), .dataAIn(dataAIn), .dataBIn(dataBIn),
        .validIn(validIn), .dataOut(dataOut), .validOut(validOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference for normal operands: exact integer sum, then RNE and FTZ.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] l, s;
        logic [63:0] ml, ms, v, m, rem, half;
        int d, e, p, k;
        if (a[30:0] >= b[30:0]) begin l = a; s = b; end
        else begin l = b; s = a; end
        d = int'(l[30:23]) - int'(s[30:23]);
        if (d >= 26) return l;
        ml = {40'd0, 1'b1, l[22:0]};
        ms = {40'd0, 1'b1, s[22:0]};
        if (l[31] == s[31]) v = (ml << d) + ms;
        else                v = (ml << d) - ms;
        if (v == 64'd0) return 32'h00000000;
        p = 0;
        for (int i = 0; i < 64; i++) if (v[i]) p = i;
        e = int'(s[30:23]) + p - 23;
        if (e <= 0) return {l[31], 31'd0};
        if (p > 23) begin
            k = p - 23;
            m = v >> k;
            rem = v & ((64'd1 << k) - 64'd1);
            half = 64'd1 << (k - 1);
            if (rem > half || (rem == half && m[0])) m = m + 64'd1;
            if (m[24]) begin m = m >> 1; e = e + 1; end
        end else begin
            m = v << (23 - p);
        end
        if (e >= 255) return {l[31], 8'hFF, 23'd0};
        return {l[31], e[7:0], m[22:0]};
    endfunction

    // One pair sampled at edge N: validOut low through N+3, result at N+4, low again at N+5.
    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] want);
        @(negedge clkIn);
        dataAIn = a; dataBIn = b; validIn = 1'b1;
        @(posedge clkIn);
        #1 validIn = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clkIn);
            #1;
            if (k == 4) begin
                check_eq({tag, "_valid"}, {31'd0, validOut}, 32'd1);
                check_eq(tag, dataOut, want);
            end else begin
                check_eq({tag, "_novalid"}, {31'd0, validOut}, 32'd0);
            end
        end
    endtask

    // Streaming scoreboard: validOut is validIn four edges later, data from the model.
    always @(posedge clkIn) begin
        if (mon_en) begin
            v_hist = {v_hist[3:0], validIn};
            if (validIn) exp_q.push_back(ref_add(dataAIn, dataBIn));
            #1;
            check_eq("stream_valid", {31'd0, validOut}, {31'd0, v_hist[4]});
            if (v_hist[4] && exp_q.size() > 0) check_eq("stream_data", dataOut, exp_q.pop_front());
        end
    end

    logic [31:0] vec_a [0:12] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800001, 32'h4B7FFFFF,
                                  32'h3F800000, 32'h80000000, 32'h00400000, 32'h3F800000, 32'h7F7FFFFF,
                                  32'h7F800000, 32'h7FC00001, 32'hFF800000};
    logic [31:0] vec_b [0:12] = '{32'h3F800000, 32'hBF000000, 32'h33800000, 32'h33800000, 32'h3F000000,
                                  32'hBF800000, 32'h80000000, 32'h00000000, 32'h00800000, 32'h7F7FFFFF,
                                  32'hFF800000, 32'h3F800000, 32'h42280000};
    logic [31:0] vec_r [0:12] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800002, 32'h4B800000,
                                  32'h00000000, 32'h80000000, 32'h00000000, 32'h3F800000, 32'h7F800000,
                                  32'h7FC00000, 32'h7FC00000, 32'hFF800000};
    string vec_n [0:12] = '{"one_plus_one", "mixed_sign", "tie_even", "tie_up", "round_carry",
                            "cancel", "negzero", "subnormal_ftz", "large_diff", "overflow",
                            "inf_minus_inf", "nan_in", "neg_inf"};

    logic [31:0] ra, rb;
    int          ea, eb;

    initial begin
        rstIn = 1'b0; validIn = 1'b0; dataAIn = 32'd0; dataBIn = 32'd0;
        mon_en = 1'b0; v_hist = 5'd0;
        #2;
        check_eq("reset_data", dataOut, 32'd0);
        check_eq("reset_valid", {31'd0, validOut}, 32'd0);
        repeat (2) @(negedge clkIn);
        rstIn = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vec_n[i], vec_a[i], vec_b[i], vec_r[i]);
        // Swapped operand order must give bit-identical results, including zero sign.
        run_vec("swap_mixed", 32'hBF000000, 32'h3FC00000, 32'h3F800000);
        run_vec("swap_cancel", 32'hBF800000, 32'h3F800000, 32'h00000000);

        @(negedge clkIn);
        mon_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ea = int'($urandom_range(1, 254));
            ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
            case ($urandom_range(0, 3))
                0: eb = int'($urandom_range(1, 254));
                3: eb = ea;
                default: eb = ea + int'($urandom_range(0, 6)) - 3;
            endcase
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
            rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
            if (eb == ea && $urandom_range(0, 1) == 1) rb = {~ra[31], ra[30:4], 4'($urandom)};
            @(negedge clkIn);
            dataAIn = ra; dataBIn = rb; validIn = 1'b1;
            @(negedge clkIn);
            dataAIn = rb; dataBIn = ra; validIn = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clkIn);
                validIn = 1'b0; dataAIn = $urandom; dataBIn = $urandom;
            end
        end
        @(negedge clkIn);
        validIn = 1'b0;
        repeat (7) @(negedge clkIn);
        check_eq("stream_drain", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // Three pairs in flight when reset hits between edges.
        @(negedge clkIn);
        dataAIn = 32'h3F800000; dataBIn = 32'h3F800000; validIn = 1'b1;
        @(negedge clkIn);
        dataAIn = 32'h40000000; dataBIn = 32'h3F800000;
        @(negedge clkIn);
        dataAIn = 32'h40400000; dataBIn = 32'h40400000;
        @(posedge clkIn);
        #3 validIn = 1'b0; rstIn = 1'b0;
        #1;
        check_eq("midrst_data", dataOut, 32'd0);
        check_eq("midrst_valid", {31'd0, validOut}, 32'd0);
        @(posedge clkIn);
        #1 check_eq("midrst_hold_valid", {31'd0, validOut}, 32'd0);
        @(negedge clkIn);
        rstIn = 1'b1;
        repeat (6) begin
            @(posedge clkIn);
            #1 check_eq("post_rst_stale", {31'd0, validOut}, 32'd0);
        end
        run_vec("post_rst", 32'h3F800000, 32'h40000000, 32'h40400000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
